// File: rtl/multicycle_controller.sv
// multicycle_controller: sequencing FSM for the 8-bit-memory multicycle
// accumulator processor. It fetches two-byte instructions into the IR,
// decodes the opcode and strobes the datapath. Every memory access is
// guarded by a watchdog that stops the core if the access is never acknowledged.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   FETCH_L | request IR high byte at PC
//   DECODE  | opcode valid; one-byte register ops execute here
//   FETCH_R | request IR low byte at PC (two-byte ops only)
//   EXEC    | JMP/JZ program-counter load, single cycle
//   MEM     | data access at IR addr field (LDA/STA/ADDM)
//   HALT    | stopped by HLT until reset
//   ERROR   | stopped by watchdog timeout until reset
module multicycle_controller #(
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned TW      = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] opcode,
  input  logic       zero,
  input  logic       mem_ack,
  output logic       mem_req,
  output logic       mem_we,
  output logic       addr_sel,
  output logic       ir_ldL,
  output logic       ir_ldR,
  output logic       pc_inc,
  output logic       pc_ld,
  output logic       acc_we,
  output logic       acc_wsel,
  output logic [1:0] alu_op,
  output logic       flag_ld,
  output logic       halted,
  output logic       bus_err
);

  typedef enum logic [2:0] {
    S_FETCH_L,
    S_DECODE,
    S_FETCH_R,
    S_EXEC,
    S_MEM,
    S_HALT,
    S_ERROR
  } state_t;

  localparam logic [3:0] OP_LDA  = 4'h0;
  localparam logic [3:0] OP_STA  = 4'h1;
  localparam logic [3:0] OP_JMP  = 4'h2;
  localparam logic [3:0] OP_JZ   = 4'h3;
  localparam logic [3:0] OP_ADDM = 4'h4;
  localparam logic [3:0] OP_MOV  = 4'hB;
  localparam logic [3:0] OP_HLT  = 4'hF;

  // The watchdog holds the number of earlier unacknowledged request cycles,
  // so the current cycle is the TIMEOUT-th one when it equals TIMEOUT-1.
  localparam logic [TW-1:0] WD_LAST = TW'(TIMEOUT - 1);

  state_t        state_q, state_d;
  logic [TW-1:0] wdog_q, wdog_d;
  logic          req_state;
  logic          stall;
  logic          wd_expire;

  assign req_state = (state_q == S_FETCH_L) || (state_q == S_FETCH_R) || (state_q == S_MEM);
  assign stall     = req_state && !mem_ack;
  // An ack in the final allowed cycle wins because stall requires !mem_ack.
  assign wd_expire = stall && (wdog_q == WD_LAST);

  // State and watchdog registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH_L;
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      wdog_q  <= wdog_d;
    end
  end

  // Next state: advance on ack, stay while stalled, trap on watchdog expiry.
  always_comb begin
    state_d = state_q;
    wdog_d  = '0;
    if (wd_expire) begin
      state_d = S_ERROR;
    end else if (stall) begin
      wdog_d = wdog_q + 1'b1;
    end else begin
      case (state_q)
        S_FETCH_L: state_d = S_DECODE;
        S_DECODE: begin
          if (!opcode[3])           state_d = S_FETCH_R;
          else if (opcode == OP_HLT) state_d = S_HALT;
          else                      state_d = S_FETCH_L;
        end
        S_FETCH_R: begin
          case (opcode)
            OP_JMP, OP_JZ:          state_d = S_EXEC;
            OP_LDA, OP_STA, OP_ADDM: state_d = S_MEM;
            default:                state_d = S_FETCH_L;
          endcase
        end
        S_EXEC:  state_d = S_FETCH_L;
        S_MEM:   state_d = S_FETCH_L;
        default: state_d = state_q;
      endcase
    end
  end

  // Output decode from state; load strobes are qualified by the ack and
  // everything is forced low while reset is asserted.
  always_comb begin
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    addr_sel = 1'b0;
    ir_ldL   = 1'b0;
    ir_ldR   = 1'b0;
    pc_inc   = 1'b0;
    pc_ld    = 1'b0;
    acc_we   = 1'b0;
    acc_wsel = 1'b0;
    alu_op   = 2'b00;
    flag_ld  = 1'b0;
    halted   = 1'b0;
    bus_err  = 1'b0;
    if (!rst) begin
      case (state_q)
        S_FETCH_L: begin
          mem_req = 1'b1;
          ir_ldL  = mem_ack;
          pc_inc  = mem_ack;
        end
        S_FETCH_R: begin
          mem_req = 1'b1;
          ir_ldR  = mem_ack;
          pc_inc  = mem_ack;
        end
        S_DECODE: begin
          if (opcode[3] && (opcode[2] == 1'b0)) begin
            acc_we  = 1'b1;
            flag_ld = 1'b1;
            alu_op  = (opcode == OP_MOV) ? 2'b11 : opcode[1:0];
          end
        end
        S_EXEC: begin
          pc_ld = (opcode == OP_JMP) || ((opcode == OP_JZ) && zero);
        end
        S_MEM: begin
          mem_req  = 1'b1;
          addr_sel = 1'b1;
          mem_we   = (opcode == OP_STA);
          if (mem_ack && (opcode == OP_LDA)) begin
            acc_we   = 1'b1;
            acc_wsel = 1'b1;
            flag_ld  = 1'b1;
          end
          if (mem_ack && (opcode == OP_ADDM)) begin
            acc_we  = 1'b1;
            flag_ld = 1'b1;
          end
        end
        S_HALT:  halted  = 1'b1;
        S_ERROR: bus_err = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller. The reference model generates the expected
// per-cycle strobe trace of each instruction from its class and the
// per-access wait counts.
module tb_multicycle_controller;
  localparam int TIMEOUT = 15;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] opcode;
  logic       zero;
  logic       mem_ack;
  logic       mem_req, mem_we, addr_sel, ir_ldL, ir_ldR, pc_inc, pc_ld;
  logic       acc_we, acc_wsel, flag_ld, halted, bus_err;
  logic [1:0] alu_op;

  multicycle_controller #(.TIMEOUT(TIMEOUT), .TW(8)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ack(mem_ack),
    .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel),
    .ir_ldL(ir_ldL), .ir_ldR(ir_ldR), .pc_inc(pc_inc), .pc_ld(pc_ld),
    .acc_we(acc_we), .acc_wsel(acc_wsel), .alu_op(alu_op), .flag_ld(flag_ld),
    .halted(halted), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  // Output vector layout: req we asel ldL ldR inc pcld awe wsel alu[1:0] flg hlt berr
  localparam logic [13:0] REQ  = 14'h2000;
  localparam logic [13:0] WE   = 14'h1000;
  localparam logic [13:0] ASEL = 14'h0800;
  localparam logic [13:0] LDL  = 14'h0400;
  localparam logic [13:0] LDR  = 14'h0200;
  localparam logic [13:0] INC  = 14'h0100;
  localparam logic [13:0] PCLD = 14'h0080;
  localparam logic [13:0] AWE  = 14'h0040;
  localparam logic [13:0] WSEL = 14'h0020;
  localparam logic [13:0] FLG  = 14'h0004;
  localparam logic [13:0] HLTD = 14'h0002;
  localparam logic [13:0] BERR = 14'h0001;

  logic [13:0] act;
  assign act = {mem_req, mem_we, addr_sel, ir_ldL, ir_ldR, pc_inc, pc_ld,
                acc_we, acc_wsel, alu_op, flag_ld, halted, bus_err};

  logic [13:0] exp_vec   = '0;
  logic        exp_valid = 1'b0;
  string       exp_tag   = "";

  int    lit_cnt = 0;
  int    lit_act [4];
  int    lit_exp [4];
  string lit_name[4];

  int n_vec = 0, n_err = 0;
  int n_cyc = 0, n_inc = 0, n_pcld = 0, n_req = 0;

  function automatic logic rnd();
    return logic'($urandom_range(0, 1));
  endfunction

  function automatic logic [13:0] alu(input logic [1:0] v);
    return {9'b0, v, 3'b000};
  endfunction

  // Single compare process: per-cycle trace check plus pending literal checks.
  always @(negedge clk) begin
    n_cyc++;
    if (pc_inc)  n_inc++;
    if (pc_ld)   n_pcld++;
    if (mem_req) n_req++;
    if (exp_valid) begin
      n_vec++;
      if (act !== exp_vec) begin
        n_err++;
        $display("FAIL %s @%0t: got %b want %b", exp_tag, $time, act, exp_vec);
      end
    end
    for (int i = 0; i < lit_cnt; i++) begin
      n_vec++;
      if (lit_act[i] != lit_exp[i]) begin
        n_err++;
        $display("FAIL %s: got %0d want %0d", lit_name[i], lit_act[i], lit_exp[i]);
      end
    end
  end

  task automatic lit(input string name, input int a, input int e);
    lit_name[lit_cnt] = name;
    lit_act[lit_cnt]  = a;
    lit_exp[lit_cnt]  = e;
    lit_cnt++;
  endtask

  task automatic cycle(input logic ack, input logic z, input logic [13:0] e, input string tag);
    mem_ack   = ack;
    zero      = z;
    exp_vec   = e;
    exp_tag   = tag;
    exp_valid = 1'b1;
    @(posedge clk);
    #1;
    lit_cnt = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle(rnd(), rnd(), '0, "reset");
    cycle(rnd(), rnd(), '0, "reset");
    rst = 1'b0;
  endtask

  task automatic stop_cycles(input int n, input logic [13:0] v, input string tag);
    for (int i = 0; i < n; i++) cycle(rnd(), rnd(), v, tag);
  endtask

  // One memory access: `waits` unacked cycles then the ack, unless the
  // watchdog's TIMEOUT unacked cycles run out first.
  task automatic do_access(input logic we, input logic asel, input int waits,
                           input logic [13:0] on_ack, input string tag, output bit err);
    logic [13:0] base;
    base = REQ | (we ? WE : 14'h0) | (asel ? ASEL : 14'h0);
    err  = 1'b0;
    for (int c = 1; c <= TIMEOUT; c++) begin
      if (c == waits + 1) begin
        cycle(1'b1, rnd(), base | on_ack, tag);
        return;
      end
      cycle(1'b0, rnd(), base, tag);
    end
    err = 1'b1;
  endtask

  task automatic run_instr(input logic [3:0] op, input logic zv,
                           input int w0, input int w1, input int w2, output bit stopped);
    bit          err;
    logic [13:0] e;
    stopped = 1'b0;
    opcode  = 4'($urandom);
    do_access(1'b0, 1'b0, w0, LDL | INC, "fetch_l", err);
    if (err) begin
      stop_cycles(3, BERR, "bus_err");
      stopped = 1'b1;
      return;
    end
    opcode = op;
    e = '0;
    if (op[3]) begin
      case (op[2:0])
        3'b000, 3'b001, 3'b010: e = AWE | FLG | alu(op[1:0]);
        3'b011:                 e = AWE | FLG | alu(2'b11);
        default:                e = '0;
      endcase
    end
    cycle(rnd(), rnd(), e, "decode");
    if (op == 4'hF) begin
      stop_cycles(3, HLTD, "halted");
      stopped = 1'b1;
      return;
    end
    if (op[3]) return;
    do_access(1'b0, 1'b0, w1, LDR | INC, "fetch_r", err);
    if (!err) begin
      case (op)
        4'h2, 4'h3: cycle(rnd(), zv, ((op == 4'h2) || zv) ? PCLD : 14'h0, "exec");
        4'h0: do_access(1'b0, 1'b1, w2, AWE | WSEL | FLG, "mem_lda", err);
        4'h1: do_access(1'b1, 1'b1, w2, 14'h0, "mem_sta", err);
        4'h4: do_access(1'b0, 1'b1, w2, AWE | FLG, "mem_addm", err);
        default: ;
      endcase
    end
    if (err) begin
      stop_cycles(3, BERR, "bus_err");
      stopped = 1'b1;
    end
  endtask

  function automatic int rand_wait();
    if ($urandom_range(0, 19) == 0) return int'($urandom_range(TIMEOUT - 2, TIMEOUT));
    return int'($urandom_range(0, 3));
  endfunction

  initial begin
    bit stopped;
    int s_cyc, s_inc, s_pcld, s_req;
    rst = 1'b1; mem_ack = 1'b0; zero = 1'b0; opcode = 4'h0;
    @(posedge clk);
    #1;
    do_reset();

    // ADD with zero wait states: two cycles.
    s_cyc = n_cyc;
    run_instr(4'h8, 1'b0, 0, 0, 0, stopped);
    lit("add_cycles", n_cyc - s_cyc, 2);

    // LDA with three wait states per access: 4+1+4+4 cycles, two PC increments.
    s_cyc = n_cyc; s_inc = n_inc;
    run_instr(4'h0, 1'b0, 3, 3, 3, stopped);
    lit("lda_cycles", n_cyc - s_cyc, 13);
    lit("lda_pc_inc", n_inc - s_inc, 2);

    // JZ taken then not taken, then JMP with zero low.
    s_pcld = n_pcld;
    run_instr(4'h3, 1'b1, 0, 0, 0, stopped);
    lit("jz_taken_pcld", n_pcld - s_pcld, 1);
    s_pcld = n_pcld;
    run_instr(4'h3, 1'b0, 1, 2, 0, stopped);
    lit("jz_not_taken_pcld", n_pcld - s_pcld, 0);
    s_pcld = n_pcld;
    run_instr(4'h2, 1'b0, 0, 1, 0, stopped);
    lit("jmp_pcld", n_pcld - s_pcld, 1);

    // STA never acknowledged: two fetch requests plus TIMEOUT data requests.
    s_req = n_req;
    run_instr(4'h1, 1'b0, 0, 0, TIMEOUT, stopped);
    lit("sta_timeout_reqs", n_req - s_req, 17);
    do_reset();

    // STA acknowledged in the last allowed cycle completes normally.
    s_cyc = n_cyc;
    run_instr(4'h1, 1'b0, 0, 0, TIMEOUT - 1, stopped);
    lit("sta_late_ack_cycles", n_cyc - s_cyc, 18);

    // HLT: no requests for 50 cycles despite random acks.
    run_instr(4'hF, 1'b0, 0, 0, 0, stopped);
    s_req = n_req;
    stop_cycles(50, HLTD, "halted");
    lit("halt_reqs", n_req - s_req, 0);
    do_reset();

    // Reset while FETCH_R is stalled, then a normal instruction from FETCH_L.
    opcode = 4'($urandom);
    cycle(1'b1, rnd(), REQ | LDL | INC, "fetch_l");
    opcode = 4'h0;
    cycle(rnd(), rnd(), '0, "decode");
    for (int i = 0; i < 5; i++) cycle(1'b0, rnd(), REQ, "fetch_r_stall");
    rst = 1'b1;
    cycle(rnd(), rnd(), '0, "reset_mid_fetch_r");
    rst = 1'b0;
    run_instr(4'h9, 1'b0, 0, 0, 0, stopped);

    // Randomized instruction stream.
    for (int k = 0; k < 400; k++) begin
      logic [3:0] op;
      op = 4'($urandom);
      run_instr(op, rnd(), rand_wait(), rand_wait(), rand_wait(), stopped);
      if (stopped) do_reset();
    end
    do_reset();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Control FSM for the 8-bit-memory multicycle accumulator processor.
- Sequences two-byte instruction fetch into the instruction register: high byte via ir_ldL, low byte via ir_ldR.
- Decodes the 4-bit opcode and drives the PC, memory, accumulator-file, ALU and flag strobes for each instruction class.
- Owns the memory request handshake, with a bounded-wait watchdog.

Parameters:
- TIMEOUT, 15: maximum cycles mem_req may stay unacknowledged before a bus error (1..255).
- TW, 8: width of the watchdog counter; must satisfy TIMEOUT < 2**TW.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- opcode  in  4  IR opcode field (IR bits 15:12), valid from the cycle after ir_ldL.
- zero  in  1  datapath zero flag register output.
- mem_ack  in  1  memory completes the current access this cycle; read data valid this cycle.
- mem_req  out  1  memory access request.
- mem_we  out  1  request is a write; valid only while mem_req=1.
- addr_sel  out  1  address mux select: 0=PC, 1=IR addr field.
- ir_ldL  out  1  load IR high byte.
- ir_ldR  out  1  load IR low byte.
- pc_inc  out  1  PC <= PC+1.
- pc_ld  out  1  PC <= IR addr field.
- acc_we  out  1  write accumulator selected by IR AccDst.
- acc_wsel  out  1  accumulator write source: 0=ALU, 1=memory data.
- alu_op  out  2  operation code: 00 ADD, 01 SUB, 10 AND, 11 PASS-B.
- flag_ld  out  1  load zero flag from the ALU result.
- halted  out  1  core stopped by HLT.
- bus_err  out  1  core stopped by watchdog timeout.

Behaviour:
- Reset (rst high at a rising clk edge): state=FETCH_L, watchdog=0. All strobes are 0 after reset, including halted and bus_err. Reset takes effect in any state, including mid-handshake; an outstanding request is dropped with no wait for mem_ack.
- Opcode classes:
  - 0xxx = two-byte memory/branch. 0000 LDA, 0001 STA, 0010 JMP, 0011 JZ, 0100 ADDM; 0101-0111 = two-byte NOP.
  - 1xxx = one-byte register ops using AccDst/AccSrc. 1000 ADD, 1001 SUB, 1010 AND, 1011 MOV; 1100-1110 = NOP; 1111 HLT.
- States: FETCH_L, FETCH_R, DECODE, MEM, HALT, ERROR.
- FETCH_L: mem_req=1, addr_sel=0, mem_we=0. In the mem_ack cycle: ir_ldL=1, pc_inc=1, next state DECODE.
- DECODE, opcode[3]=0: next state FETCH_R.
- FETCH_R: same handshake as FETCH_L, with ir_ldR=1 and pc_inc=1 on ack. Next state:
  - JMP: DECODE-free execute — pc_ld pulses in the cycle after ack, then FETCH_L.
  - JZ: same as JMP, but pc_ld is asserted only if zero=1.
  - LDA, STA, ADDM: MEM.
  - Two-byte NOP: FETCH_L.
- Execute cycle (JMP/JZ) is a single cycle state inside FETCH_R's exit; it may be implemented as a sub-state.
- DECODE, opcode[3]=1: single execute cycle in DECODE itself, then FETCH_L.
  - ADD/SUB/AND: acc_we=1, acc_wsel=0, flag_ld=1, alu_op = opcode[1:0].
  - MOV: alu_op=11, acc_we=1, flag_ld=1.
  - 1100-1110: no strobes.
  - HLT: next state HALT.
- MEM: mem_req=1, addr_sel=1, mem_we=1 for STA only. On ack:
  - LDA: acc_we=1, acc_wsel=1, flag_ld=1.
  - ADDM: acc_we=1, acc_wsel=0, alu_op=00, flag_ld=1.
  - STA: nothing further.
  - Next state FETCH_L.
- Handshake rules:
  - mem_req, mem_we and addr_sel stay stable from the request until the ack cycle inclusive.
  - mem_req drops in the cycle after ack, except that FETCH_L→DECODE always leaves a one-cycle gap.
  - mem_ack while mem_req=0 is ignored.
  - Every load/increment strobe is a single-cycle pulse coincident with the ack.
- Watchdog:
  - Counts cycles with mem_req=1 and mem_ack=0; cleared on ack or state change.
  - When count reaches TIMEOUT with no ack, next state ERROR.
  - An ack in the same cycle the count equals TIMEOUT wins: the access completes normally.
- HALT: halted=1, all other strobes 0; exits only via rst.
- ERROR: bus_err=1, all other strobes 0; exits only via rst.
- Cycle counts with zero wait states (ack in the first request cycle):
  - One-byte op: 2 cycles (FETCH_L, DECODE).
  - JMP/JZ: 4 cycles.
  - LDA/STA/ADDM: 4 cycles.
- Strobe exclusivity: ir_ldL and ir_ldR are never high in the same cycle; pc_inc and pc_ld are never high in the same cycle.

Test Plan:
- Reset then zero-wait ack, memory bytes 0x80,0x00 (ADD) → cycle 1: ir_ldL=1, pc_inc=1; cycle 2: acc_we=1, alu_op=00, flag_ld=1; cycle 3: mem_req=1, addr_sel=0.
- LDA with 3 wait states per access → FETCH_L 4 cycles, DECODE 1, FETCH_R 4, MEM 4 with addr_sel=1, mem_we=0. On final ack: acc_we=1, acc_wsel=1; total 13 cycles; exactly two pc_inc pulses.
- JZ twice, first with zero=1 then zero=0 → pc_ld pulses once, in the cycle after the FETCH_R ack; second instance shows no pc_ld, and the next fetch uses addr_sel=0.
- STA with mem_ack held low → bus_err=1 after exactly TIMEOUT=15 request cycles, mem_req=0 afterwards. Second run with ack arriving on cycle 15 → completes normally, bus_err=0.
- HLT (0xF0) → halted=1 from the cycle after DECODE; mem_req stays 0 for 50 cycles despite random mem_ack.
- rst asserted during a stalled FETCH_R, then released → next cycle state FETCH_L with mem_req=1, addr_sel=0; all strobes low during the reset cycle.
